// File: rtl/adc_histo_fill_pkg.sv
// Shared types for the ADC code-density histogram filler.
// FSM state encoding and the sample-counter width.
package adc_histo_fill_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StAcqIdle = 3'd2,
        StAcqRd   = 3'd3,
        StAcqWait = 3'd4,
        StAcqWr   = 3'd5,
        StDone    = 3'd6
    } state_e;

    localparam int unsigned CntWidth = 32;

endpackage

// File: rtl/adc_histo_fill_if.sv
// ADC sample stream: valid/ready handshake carrying one code per transfer.
interface adc_histo_fill_if #(
    parameter int unsigned LENGTH_ADDR = 10
) ();

    logic                   adc_valid;
    logic [LENGTH_ADDR-1:0] adc_code;
    logic                   adc_ready;

    modport master (
        output adc_valid,
        output adc_code,
        input  adc_ready
    );

    modport slave (
        input  adc_valid,
        input  adc_code,
        output adc_ready
    );

endinterface

// File: rtl/adc_histo_fill_sat_incr.sv
// Combinational saturating +1; bins hold at all-ones instead of wrapping.
module adc_histo_fill_sat_incr #(
    parameter int unsigned WIDTH_DATA = 16
) (
    input  logic [WIDTH_DATA-1:0] val_i,
    output logic [WIDTH_DATA-1:0] nxt_o,
    output logic                  sat_hit_o
);

    localparam logic [WIDTH_DATA-1:0] MaxVal = {WIDTH_DATA{1'b1}};

    always_comb begin
        sat_hit_o = (val_i == MaxVal);
        nxt_o     = sat_hit_o ? val_i : val_i + 1'b1;
    end

endmodule

// File: rtl/adc_histo_fill.sv
// Code-density histogram builder: zero-fills the bin RAM through port A, then
// performs one saturating read-modify-write per accepted ADC code.
module adc_histo_fill
    import adc_histo_fill_pkg::*;
#(
    parameter int unsigned WIDTH_DATA  = 16,
    parameter int unsigned LENGTH_ADDR = 10,
    parameter int unsigned N_SAMPLES   = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    adc_histo_fill_if.slave        adc,
    output logic                   wen,
    output logic [LENGTH_ADDR-1:0] addr_a,
    output logic [WIDTH_DATA-1:0]  din_a,
    input  logic [WIDTH_DATA-1:0]  dout_a,
    output logic                   busy,
    output logic                   done,
    output logic                   sat,
    output logic [CntWidth-1:0]    sample_cnt
);

    localparam logic [LENGTH_ADDR-1:0] AddrMax = {LENGTH_ADDR{1'b1}};
    localparam logic [CntWidth-1:0]    CntEnd  = CntWidth'(N_SAMPLES);

    state_e                 state_q, state_d;
    logic                   wen_q, wen_d;
    logic [LENGTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_DATA-1:0]  din_q, din_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sat_q, sat_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [LENGTH_ADDR-1:0] code_q, code_d;

    logic [WIDTH_DATA-1:0]  incr_val;
    logic                   incr_hit;

    adc_histo_fill_sat_incr #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_sat_incr (
        .val_i     (dout_a),
        .nxt_o     (incr_val),
        .sat_hit_o (incr_hit)
    );

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        // start from any state restarts the sweep; an in-flight RMW is dropped
        if (start) begin
            state_d = StClear;
            wen_d   = 1'b1;
            addr_d  = '0;
            din_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_d = '0;
                end
                StClear: begin
                    if (addr_q == AddrMax) begin
                        state_d = StAcqIdle;
                    end else begin
                        wen_d  = 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
                StAcqIdle: begin
                    if (adc.adc_valid) begin
                        code_d  = adc.adc_code;
                        addr_d  = adc.adc_code;
                        state_d = StAcqRd;
                    end
                end
                StAcqRd: begin
                    state_d = StAcqWait;
                end
                StAcqWait: begin
                    // dout_a now holds the bin read issued in StAcqRd
                    wen_d   = 1'b1;
                    addr_d  = code_q;
                    din_d   = incr_val;
                    sat_d   = sat_q | incr_hit;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StAcqWr;
                end
                StAcqWr: begin
                    if (cnt_q == CntEnd) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                    end else begin
                        state_d = StAcqIdle;
                    end
                end
                StDone: begin
                    addr_d = '0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign adc.adc_ready = (state_q == StAcqIdle);
    assign wen           = wen_q;
    assign addr_a        = addr_q;
    assign din_a         = din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sat           = sat_q;
    assign sample_cnt    = cnt_q;

endmodule

// File: tb/tb_adc_histo_fill.sv
// Bench for adc_histo_fill with a 16-bin, 4-bit-counter configuration and a
// behavioural registered-read RAM on port A.
module tb_adc_histo_fill;

    localparam int unsigned W = 4;
    localparam int unsigned L = 4;
    localparam int unsigned N = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          preload = 1'b0;
    logic          wen;
    logic [L-1:0]  addr_a;
    logic [W-1:0]  din_a;
    logic [W-1:0]  dout_a;
    logic          busy;
    logic          done;
    logic          sat;
    logic [31:0]   sample_cnt;
    logic [W-1:0]  ram [16];

    adc_histo_fill_if #(.LENGTH_ADDR(L)) adc_bus ();

    adc_histo_fill #(
        .WIDTH_DATA  (W),
        .LENGTH_ADDR (L),
        .N_SAMPLES   (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .adc        (adc_bus),
        .wen        (wen),
        .addr_a     (addr_a),
        .din_a      (din_a),
        .dout_a     (dout_a),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 4'hF;
        end else if (wen) begin
            ram[addr_a] <= din_a;
        end
        dout_a <= ram[addr_a];
    end

    typedef struct {
        int           cyc;
        logic [L-1:0] addr;
        logic [W-1:0] val;
    } exp_t;

    typedef struct {
        logic [L-1:0] code;
        bit           hold;
        logic [31:0]  exp_cnt;
        logic [W-1:0] exp_bin;
    } vec_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           model_hist [16];
    int unsigned  model_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] sat_inc(input int v);
        return (v >= 15) ? 4'hF : W'(v + 1);
    endfunction

    // Every wait goes through here so RMW writes are checked each cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_write_cycle", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            chk("rmw_write", {wen, addr_a, din_a}, {1'b1, sb[0].addr, sb[0].val});
            void'(sb.pop_front());
        end else if (wen && din_a != '0) begin
            chk("stray_write", {wen, addr_a, din_a}, {1'b0, addr_a, din_a});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_hist[i] = 0;
        model_cnt = 0;
    endtask

    task automatic send(input logic [L-1:0] c, input bit hold);
        int w = 0;
        bit seen = 1'b0;
        adc_bus.adc_valid = 1'b1;
        adc_bus.adc_code  = c;
        if (model_cnt != N) begin
            while (!adc_bus.adc_ready && w < 40) begin
                tick();
                w++;
            end
            chk("accept", adc_bus.adc_ready, 1);
            if (adc_bus.adc_ready) begin
                sb.push_back('{cyc: cyc + 3, addr: c, val: sat_inc(model_hist[c])});
                if (model_hist[c] < 15) model_hist[c]++;
                model_cnt++;
            end
            tick();
            if (hold) repeat (3) tick();
        end else begin
            repeat (8) begin
                tick();
                seen |= adc_bus.adc_ready;
            end
            chk("reject_after_done", seen, 0);
        end
        adc_bus.adc_valid = 1'b0;
    endtask

    task automatic settle();
        int w = 0;
        do begin
            tick();
            w++;
        end while (!adc_bus.adc_ready && !done && w < 20);
        chk("settle", adc_bus.adc_ready | done, 1);
    endtask

    task automatic do_clear();
        int w = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_entry", {wen, addr_a, din_a, busy, done, sat, sample_cnt},
            {1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        while (!adc_bus.adc_ready && w < 30) begin
            tick();
            w++;
        end
        chk("clear_to_ready", adc_bus.adc_ready, 1);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   k;
        int   sum;
        vecs[0] = '{code: 4'd5,  hold: 1'b0, exp_cnt: 32'd1, exp_bin: 4'd1};
        vecs[1] = '{code: 4'd5,  hold: 1'b0, exp_cnt: 32'd2, exp_bin: 4'd2};
        vecs[2] = '{code: 4'd9,  hold: 1'b0, exp_cnt: 32'd3, exp_bin: 4'd1};
        vecs[3] = '{code: 4'd0,  hold: 1'b1, exp_cnt: 32'd4, exp_bin: 4'd1};
        vecs[4] = '{code: 4'd15, hold: 1'b1, exp_cnt: 32'd5, exp_bin: 4'd1};
        vecs[5] = '{code: 4'd5,  hold: 1'b0, exp_cnt: 32'd6, exp_bin: 4'd3};
        adc_bus.adc_valid = 1'b0;
        adc_bus.adc_code  = '0;
        model_reset();

        // Reset values, with start colliding with rst on one cycle
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_outputs", {wen, addr_a, din_a, busy, done, sat, sample_cnt},
            {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0});
        chk("rst_ready", adc_bus.adc_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_after_rst_start", {busy, wen, adc_bus.adc_ready}, 3'b000);

        // Clear sweep over a RAM preloaded with all-ones
        preload = 1'b1;
        tick();
        preload = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("clear_%0d", i), {wen, addr_a, din_a, adc_bus.adc_ready},
                {1'b1, 4'(i), 4'd0, 1'b0});
        end
        tick();
        chk("ready_cycle17", {adc_bus.adc_ready, busy, wen}, 3'b110);
        for (int i = 0; i < 16; i++) chk($sformatf("bin_zero_%0d", i), ram[i], 0);

        // Basic RMW; held valid through RD/WAIT/WR must not add counts
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].code, vecs[i].hold);
            settle();
            chk($sformatf("vec%0d_cnt", i), sample_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_bin", i), ram[vecs[i].code], vecs[i].exp_bin);
        end
        chk("no_sat_yet", sat, 0);

        // Restart during ACQ_RD of the 4th sample
        do_clear();
        for (int i = 0; i < 3; i++) begin
            send(4'd7, 1'b0);
            settle();
        end
        chk("pre_restart_cnt", sample_cnt, 3);
        adc_bus.adc_valid = 1'b1;
        adc_bus.adc_code  = 4'd2;
        chk("fourth_ready", adc_bus.adc_ready, 1);
        tick();
        adc_bus.adc_valid = 1'b0;
        chk("in_acq_rd", {adc_bus.adc_ready, wen, busy}, 3'b001);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr0", {wen, addr_a, din_a, sample_cnt}, {1'b1, 4'd0, 4'd0, 32'd0});
        k = 0;
        while (!adc_bus.adc_ready && k < 30) begin
            tick();
            k++;
        end
        chk("restart_ready", adc_bus.adc_ready, 1);
        chk("restart_bins", {ram[7], ram[2]}, 8'h00);
        model_reset();

        // Saturation: 20 hits on code 3 with 4-bit bins
        for (int i = 0; i < 20; i++) begin
            send(4'd3, 1'b0);
            settle();
            if (i == 14) chk("sat_before_overflow", {sat, ram[3]}, {1'b0, 4'hF});
        end
        chk("sat_bin", ram[3], 15);
        chk("sat_flag", sat, 1);
        chk("sat_cnt", sample_cnt, 20);

        // Completion at sample 24; later samples are refused
        for (int i = 0; i < 3; i++) begin
            send(4'd1, 1'b0);
            settle();
        end
        send(4'd1, 1'b0);
        tick();
        tick();
        chk("last_write_no_done", {wen, done, busy}, 3'b101);
        tick();
        chk("done_rise", {done, busy, wen, addr_a, adc_bus.adc_ready},
            {1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
        send(4'd2, 1'b0);
        send(4'd2, 1'b0);
        chk("done_cnt", sample_cnt, 24);
        chk("done_held", done, 1);
        sum = 0;
        for (int i = 0; i < 16; i++) sum += int'(ram[i]);
        // 15 on bin 3 (five increments lost to saturation) plus 4 on bin 1
        chk("histo_total", 64'(sum), 64'd19);

        // start from DONE: done drops in the first CLEAR cycle
        do_clear();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
